bip_control_unit: RTL
=====================

// Module: bip_control_unit
// PURPOSE
//  BIP sequencer. Fetches from the synchronous-read program memory (PC out, 1-cycle read latency),
//  decodes the 5-bit opcode and drives the accumulator/ALU/data-RAM controls.
//  Sits between program memory and the datapath. Multi-cycle: 2 cycles/instr, 3 for RAM-operand ops.
// PARAMETERS
//  NB_DATA            16  instruction width
//  NB_OPCODE           5  opcode field [15:11]
//  LOG2_N_INSMEM_ADDR 11  PC / program address width; also operand width [10:0]
// PORTS
//  i_clock          in   1   clock, rising edge
//  i_reset          in   1   async active-high reset
//  i_enable         in   1   run enable; 0 freezes FSM and PC
//  i_instruction    in   16  program memory read data
//  o_insmem_addr    out  11  program address (= PC)
//  o_insmem_enable  out  1   program memory read enable
//  o_operand        out  11  IR[10:0], to datapath/RAM address
//  o_sel_a          out  2   ACC source: 00 RAM data, 01 operand (immediate), 10 ALU result
//  o_sel_b          out  1   ALU B source: 0 RAM data, 1 operand
//  o_op             out  1   ALU op: 0 add, 1 sub
//  o_wr_acc         out  1   ACC write strobe
//  o_wr_ram         out  1   data RAM write strobe (ACC -> RAM[o_operand])
//  o_rd_ram         out  1   data RAM read strobe (RAM[o_operand])
//  o_halt           out  1   high while halted
// BEHAVIOUR
//  Opcodes: 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI, 00110 SUB,
//   00111 SUBI; 01000-11111 = NOP (PC advances, no strobes).
//  Reset (async): state=IDLE, PC=0, IR=0; all outputs 0 while reset held and in IDLE.
//  States (advance only when i_enable=1; when 0, state/PC/IR hold and all strobes forced 0):
//   IDLE  : -> FETCH.
//   FETCH : o_insmem_enable=1, o_insmem_addr=PC. -> DECODE.
//   DECODE: i_instruction valid; IR <= i_instruction.
//    HLT -> HALT, PC unchanged.
//    STO -> o_wr_ram=1; PC<=PC+1; -> FETCH.
//    LDI -> o_wr_acc=1, o_sel_a=01; PC<=PC+1; -> FETCH.
//    ADDI/SUBI -> o_wr_acc=1, o_sel_a=10, o_sel_b=1, o_op=0/1; PC<=PC+1; -> FETCH.
//    LD/ADD/SUB -> o_rd_ram=1; -> OPER.
//    NOP -> PC<=PC+1; -> FETCH.
//   OPER  : from IR. LD: o_wr_acc=1, o_sel_a=00. ADD/SUB: o_wr_acc=1, o_sel_a=10, o_sel_b=0,
//           o_op=0/1. PC<=PC+1; -> FETCH.
//   HALT  : o_halt=1, all strobes 0. Exit only by reset.
//  o_operand: i_instruction[10:0] in DECODE; IR[10:0] otherwise.
//  Strobes are Moore/decode outputs, valid only in their cycle. Non-strobe selects are 0 when unused.
//  PC: 11-bit, wraps 2047 -> 0 silently. Only FETCH asserts o_insmem_enable.
//  Reset mid-instruction: pending strobes are dropped immediately, nothing is retried.
//   After release, refetch from address 0.
//  i_enable dropped in DECODE/OPER: the strobe is suppressed for that cycle and re-issued when
//   i_enable returns (memory output holds because its enable is low).
// TESTING
//  1 Reset, prog[0]=LDI 3, prog[1]=HLT -> addr 0 at cycle 1, wr_acc+sel_a=01+operand=3 at cycle 2,
//    addr 1 at cycle 3, o_halt=1 from cycle 5 and holds.
//  2 prog: LDI 8, SUB 2, STO 7, HLT -> SUB: rd_ram/operand=2 then wr_acc/sel_a=10/sel_b=0/op=1.
//    Then wr_ram with operand=7; 9 cycles to HALT.
//  3 Opcode 01111 at addr 4 -> no strobes, next fetch addr 5.
//  4 PC forced to 2047 via NOP fill -> next fetch addr 0.
//  5 i_enable=0 for 3 cycles in DECODE of ADDI -> all outputs frozen/strobes 0.
//    Then exactly one wr_acc after re-enable.
//  6 Assert i_reset during OPER of LD -> wr_acc never seen, outputs 0 async.
//    After release, fetch addr 0.

Source files
------------

// File: rtl/bip_control_unit.sv
// BIP sequencer: fetches from a synchronous-read program memory, decodes the
// 5-bit opcode and drives accumulator/ALU/data-RAM controls (2 or 3 cycles per instruction).
module bip_control_unit #(
    parameter int NB_DATA            = 16,
    parameter int NB_OPCODE          = 5,
    parameter int LOG2_N_INSMEM_ADDR = 11
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic [NB_DATA-1:0]            i_instruction,
    output logic [LOG2_N_INSMEM_ADDR-1:0] o_insmem_addr,
    output logic                          o_insmem_enable,
    output logic [LOG2_N_INSMEM_ADDR-1:0] o_operand,
    output logic [1:0]                    o_sel_a,
    output logic                          o_sel_b,
    output logic                          o_op,
    output logic                          o_wr_acc,
    output logic                          o_wr_ram,
    output logic                          o_rd_ram,
    output logic                          o_halt
);

    localparam logic [NB_OPCODE-1:0] OP_HLT  = 5'b00000;
    localparam logic [NB_OPCODE-1:0] OP_STO  = 5'b00001;
    localparam logic [NB_OPCODE-1:0] OP_LD   = 5'b00010;
    localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'b00011;
    localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'b00100;
    localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'b00101;
    localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'b00110;
    localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SEL_A_RAM = 2'b00;
    localparam logic [1:0] SEL_A_IMM = 2'b01;
    localparam logic [1:0] SEL_A_ALU = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_OPER   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t                          state_q, state_d;
    logic [LOG2_N_INSMEM_ADDR-1:0]   pc_q, pc_d;
    logic [NB_DATA-1:0]              ir_q, ir_d;

    logic [NB_OPCODE-1:0]            dec_opcode;
    logic [NB_OPCODE-1:0]            ir_opcode;
    logic [LOG2_N_INSMEM_ADDR-1:0]   pc_inc;

    assign dec_opcode = i_instruction[NB_DATA-1 -: NB_OPCODE];
    assign ir_opcode  = ir_q[NB_DATA-1 -: NB_OPCODE];
    // Natural 11-bit wrap from 2047 back to 0.
    assign pc_inc     = pc_q + 1'b1;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ir_d            = ir_q;
        o_insmem_addr   = pc_q;
        o_insmem_enable = 1'b0;
        o_operand       = ir_q[LOG2_N_INSMEM_ADDR-1:0];
        o_sel_a         = SEL_A_RAM;
        o_sel_b         = 1'b0;
        o_op            = 1'b0;
        o_wr_acc        = 1'b0;
        o_wr_ram        = 1'b0;
        o_rd_ram        = 1'b0;
        o_halt          = (state_q == S_HALT);

        case (state_q)
            S_IDLE: begin
                if (i_enable) state_d = S_FETCH;
            end

            S_FETCH: begin
                if (i_enable) begin
                    o_insmem_enable = 1'b1;
                    state_d         = S_DECODE;
                end
            end

            // Memory data is valid here and stays valid while disabled, since the
            // read enable is only raised in FETCH.
            S_DECODE: begin
                o_operand = i_instruction[LOG2_N_INSMEM_ADDR-1:0];
                if (i_enable) begin
                    ir_d = i_instruction;
                    case (dec_opcode)
                        OP_HLT: begin
                            state_d = S_HALT;
                        end
                        OP_STO: begin
                            o_wr_ram = 1'b1;
                            pc_d     = pc_inc;
                            state_d  = S_FETCH;
                        end
                        OP_LDI: begin
                            o_wr_acc = 1'b1;
                            o_sel_a  = SEL_A_IMM;
                            pc_d     = pc_inc;
                            state_d  = S_FETCH;
                        end
                        OP_ADDI, OP_SUBI: begin
                            o_wr_acc = 1'b1;
                            o_sel_a  = SEL_A_ALU;
                            o_sel_b  = 1'b1;
                            o_op     = (dec_opcode == OP_SUBI);
                            pc_d     = pc_inc;
                            state_d  = S_FETCH;
                        end
                        OP_LD, OP_ADD, OP_SUB: begin
                            o_rd_ram = 1'b1;
                            state_d  = S_OPER;
                        end
                        default: begin
                            pc_d    = pc_inc;
                            state_d = S_FETCH;
                        end
                    endcase
                end
            end

            S_OPER: begin
                if (i_enable) begin
                    o_wr_acc = 1'b1;
                    if (ir_opcode != OP_LD) begin
                        o_sel_a = SEL_A_ALU;
                        o_op    = (ir_opcode == OP_SUB);
                    end
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
